// File: rtl/snow64_instr_cache_set_assoc.sv
// snow64_instr_cache_set_assoc
//   N-way set-associative instruction cache sitting between the fetch stage
//   and the memory arbiter. One outstanding line fill at a time, per-set
//   round-robin replacement, flush-all invalidate and a busy/stall output.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   in_req_read_req/addr   fetch request and byte address (dropped while busy)
//   in_invalidate_all      clear every valid bit
//   in_mem_access_valid    one-cycle pulse, fill line on in_mem_access_data
//   out_req_read_valid     one-cycle pulse, out_req_read_instr is valid
//   out_mem_access_req     line-fill request, held until the fill arrives
//   out_mem_access_addr    line-aligned fill address
//   out_busy               cache cannot accept a request this cycle
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | lookup on request; hit answers next cycle, miss goes to ST_MISS
// ST_MISS | fill request outstanding, waiting for in_mem_access_valid

module snow64_instr_cache_set_assoc #(
  parameter int NUM_WAYS     = 2,
  parameter int NUM_SETS     = 32,
  parameter int WIDTH__LINE  = 256,
  parameter int WIDTH__INSTR = 32,
  parameter int WIDTH__ADDR  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_req_read_req,
  input  logic [WIDTH__ADDR-1:0]  in_req_read_addr,
  input  logic                    in_invalidate_all,
  input  logic                    in_mem_access_valid,
  input  logic [WIDTH__LINE-1:0]  in_mem_access_data,
  output logic                    out_req_read_valid,
  output logic [WIDTH__INSTR-1:0] out_req_read_instr,
  output logic                    out_mem_access_req,
  output logic [WIDTH__ADDR-1:0]  out_mem_access_addr,
  output logic                    out_busy
);

  localparam int N_INSTR  = WIDTH__LINE / WIDTH__INSTR;
  localparam int OFF_W    = $clog2(WIDTH__INSTR / 8);
  localparam int IDX_W    = $clog2(N_INSTR);
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int LINE_OFF = OFF_W + IDX_W;
  localparam int TAG_W    = WIDTH__ADDR - LINE_OFF - SET_W;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef logic [N_INSTR-1:0][WIDTH__INSTR-1:0] line_t;

  typedef enum logic {
    ST_IDLE,
    ST_MISS
  } state_t;

  state_t state_q, state_d;

  // Cache arrays. Tags and data carry no reset; valid bits gate them.
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q;
  logic [TAG_W-1:0]                  tag_mem  [NUM_WAYS][NUM_SETS];
  line_t                             data_mem [NUM_WAYS][NUM_SETS];

  // Latched miss address, split into its fields.
  logic [TAG_W-1:0] miss_tag_q;
  logic [SET_W-1:0] miss_set_q;
  logic [IDX_W-1:0] miss_idx_q;

  logic pending_inv_q;
  logic resp_busy_q;

  logic [IDX_W-1:0] req_idx;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;
  logic             unused_byte_off;

  assign req_idx = in_req_read_addr[OFF_W +: IDX_W];
  assign req_set = in_req_read_addr[LINE_OFF +: SET_W];
  assign req_tag = in_req_read_addr[WIDTH__ADDR-1 -: TAG_W];
  assign unused_byte_off = ^in_req_read_addr[OFF_W-1:0];

  line_t fill_line;
  assign fill_line = in_mem_access_data;

  logic                accept;
  logic                fill_fire;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                any_invalid;
  logic [WAY_W-1:0]    invalid_way;
  logic [WAY_W-1:0]    victim;

  assign accept    = (state_q == ST_IDLE) && !resp_busy_q && in_req_read_req;
  assign fill_fire = (state_q == ST_MISS) && in_mem_access_valid;

  // Tag compare; descending scan so the lowest hitting way wins.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[req_set][w] && (tag_mem[w][req_set] == req_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    hit = |hit_vec;
  end

  // Victim: lowest invalid way of the miss set, otherwise the round-robin way.
  always_comb begin
    any_invalid = 1'b0;
    invalid_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[miss_set_q][w]) begin
        any_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
    victim = any_invalid ? invalid_way : rr_q[miss_set_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && (in_invalidate_all || !hit)) state_d = ST_MISS;
      ST_MISS: if (in_mem_access_valid)                   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      rr_q               <= '0;
      miss_tag_q         <= '0;
      miss_set_q         <= '0;
      miss_idx_q         <= '0;
      pending_inv_q      <= 1'b0;
      resp_busy_q        <= 1'b0;
      out_req_read_valid <= 1'b0;
      out_req_read_instr <= '0;
    end else begin
      out_req_read_valid <= 1'b0;
      resp_busy_q        <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (in_invalidate_all) valid_q <= '0;
        if (accept) begin
          // An invalidate in the same cycle forces the lookup to miss.
          if (hit && !in_invalidate_all) begin
            out_req_read_valid <= 1'b1;
            out_req_read_instr <= data_mem[hit_way][req_set][req_idx];
          end else begin
            miss_tag_q <= req_tag;
            miss_set_q <= req_set;
            miss_idx_q <= req_idx;
          end
        end
      end else begin
        if (in_invalidate_all) pending_inv_q <= 1'b1;
        if (fill_fire) begin
          valid_q[miss_set_q][victim] <= 1'b1;
          if (NUM_WAYS > 1) rr_q[miss_set_q] <= rr_q[miss_set_q] + WAY_W'(1);
          out_req_read_valid <= 1'b1;
          out_req_read_instr <= fill_line[miss_idx_q];
          resp_busy_q        <= 1'b1;
          // A flush seen during the miss also drops the line just filled.
          if (pending_inv_q || in_invalidate_all) begin
            valid_q       <= '0;
            pending_inv_q <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_mem[victim][miss_set_q]  <= miss_tag_q;
      data_mem[victim][miss_set_q] <= fill_line;
    end
  end

  assign out_mem_access_req  = (state_q == ST_MISS);
  assign out_mem_access_addr = out_mem_access_req ?
                               {miss_tag_q, miss_set_q, {LINE_OFF{1'b0}}} : '0;
  assign out_busy            = (state_q == ST_MISS) || resp_busy_q;

endmodule

// File: tb/tb_snow64_instr_cache_set_assoc.sv
module tb_snow64_instr_cache_set_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, inv, mv;
  logic [63:0] addr;
  logic [255:0] mdata;
  logic        o_valid, o_mreq, o_busy;
  logic [31:0] o_instr;
  logic [63:0] o_maddr;

  logic        req4, inv4, mv4;
  logic [63:0] addr4;
  logic [127:0] mdata4;
  logic        o_valid4, o_mreq4, o_busy4;
  logic [31:0] o_instr4;
  logic [63:0] o_maddr4;

  always #5 clk = ~clk;

  snow64_instr_cache_set_assoc dut (
    .clk(clk), .rst(rst),
    .in_req_read_req(req), .in_req_read_addr(addr),
    .in_invalidate_all(inv),
    .in_mem_access_valid(mv), .in_mem_access_data(mdata),
    .out_req_read_valid(o_valid), .out_req_read_instr(o_instr),
    .out_mem_access_req(o_mreq), .out_mem_access_addr(o_maddr),
    .out_busy(o_busy)
  );

  snow64_instr_cache_set_assoc #(.NUM_WAYS(4), .NUM_SETS(8), .WIDTH__LINE(128)) dut4 (
    .clk(clk), .rst(rst),
    .in_req_read_req(req4), .in_req_read_addr(addr4),
    .in_invalidate_all(inv4),
    .in_mem_access_valid(mv4), .in_mem_access_data(mdata4),
    .out_req_read_valid(o_valid4), .out_req_read_instr(o_instr4),
    .out_mem_access_req(o_mreq4), .out_mem_access_addr(o_maddr4),
    .out_busy(o_busy4)
  );

  typedef struct {
    logic        rst, req;
    logic [63:0] addr;
    logic        inv, mv;
    logic [15:0] base;
    logic        ev;
    logic [31:0] ei;
    logic        emr;
    logic [63:0] ema;
    logic        eb;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic rq, input logic [63:0] a,
                              input logic iv, input logic m, input logic [15:0] b,
                              input logic ev, input logic [31:0] ei,
                              input logic emr, input logic [63:0] ema, input logic eb);
    vec_t v;
    v.rst = r; v.req = rq; v.addr = a; v.inv = iv; v.mv = m; v.base = b;
    v.ev = ev; v.ei = ei; v.emr = emr; v.ema = ema; v.eb = eb;
    return v;
  endfunction

  // Line whose instruction k is base+k.
  function automatic logic [255:0] make_line(input logic [15:0] base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {16'h0, base} + 32'(k);
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, nvec, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; req = v.req; addr = v.addr; inv = v.inv; mv = v.mv;
    mdata = v.mv ? make_line(v.base) : '0;
    @(posedge clk); #1;
    nvec++;
    chk("valid", 64'(o_valid), 64'(v.ev));
    chk("mem_req", 64'(o_mreq), 64'(v.emr));
    chk("mem_addr", o_maddr, v.ema);
    chk("busy", 64'(o_busy), 64'(v.eb));
    if (v.ev || v.rst) chk("instr", 64'(o_instr), 64'(v.ei));
  endtask

  task automatic apply4(input vec_t v);
    logic [255:0] l;
    l = make_line(v.base);
    req4 = v.req; addr4 = v.addr; inv4 = v.inv; mv4 = v.mv;
    mdata4 = v.mv ? l[127:0] : '0;
    @(posedge clk); #1;
    nvec++;
    chk("w4_valid", 64'(o_valid4), 64'(v.ev));
    chk("w4_mem_req", 64'(o_mreq4), 64'(v.emr));
    chk("w4_mem_addr", o_maddr4, v.ema);
    chk("w4_busy", 64'(o_busy4), 64'(v.eb));
    if (v.ev) chk("w4_instr", 64'(o_instr4), 64'(v.ei));
  endtask

  initial begin
    rst = 1'b1; req = 0; inv = 0; mv = 0; addr = '0; mdata = '0;
    req4 = 0; inv4 = 0; mv4 = 0; addr4 = '0; mdata4 = '0;

    //            rst req addr      inv mv base     ev ei        emr ema       eb
    // reset state
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    // basic miss, fill, then neighbour hit
    vecs.push_back(mk(0, 1, 64'h1000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h100, 1, 32'h100, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1004, 0, 0, 16'h0,   1, 32'h101, 0, 64'h0,    0));
    // round-robin eviction in set 0
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h0000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h200, 1, 32'h200, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h2000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h2000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h300, 1, 32'h300, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h4000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h4000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h900, 1, 32'h900, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h2004, 0, 0, 16'h0,   1, 32'h301, 0, 64'h0,    0));
    // 0x0000 was evicted; request while busy dropped; 5-cycle fill
    vecs.push_back(mk(0, 1, 64'h0000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 1, 64'h4000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 1, 64'h8000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   1, 64'h0000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h400, 1, 32'h400, 0, 64'h0,    1));
    vecs.push_back(mk(0, 1, 64'h8000, 0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h0004, 0, 0, 16'h0,   1, 32'h401, 0, 64'h0,    0));
    // invalidate in IDLE
    vecs.push_back(mk(1, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h500, 1, 32'h500, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1000, 0, 0, 16'h0,   1, 32'h500, 0, 64'h0,    0));
    vecs.push_back(mk(0, 0, 64'h0,    1, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h600, 1, 32'h600, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    // same-cycle req+invalidate misses; invalidate mid-MISS
    vecs.push_back(mk(0, 1, 64'h1008, 1, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    1, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h700, 1, 32'h702, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1008, 0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 1, 16'h800, 1, 32'h802, 0, 64'h0,    1));
    vecs.push_back(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    vecs.push_back(mk(0, 1, 64'h1008, 0, 0, 16'h0,   1, 32'h802, 0, 64'h0,    0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset two cycles into a miss: outputs drop before any clock edge.
    apply(mk(0, 1, 64'h3000, 0, 0, 16'h0, 0, 32'h0, 1, 64'h3000, 1));
    apply(mk(0, 0, 64'h0,    0, 0, 16'h0, 0, 32'h0, 1, 64'h3000, 1));
    apply(mk(0, 0, 64'h0,    0, 0, 16'h0, 0, 32'h0, 1, 64'h3000, 1));
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    chk("async_rst_mem_req", 64'(o_mreq), 64'h0);
    chk("async_rst_mem_addr", o_maddr, 64'h0);
    chk("async_rst_busy", 64'(o_busy), 64'h0);
    chk("async_rst_valid", 64'(o_valid), 64'h0);
    chk("async_rst_instr", 64'(o_instr), 64'h0);
    @(posedge clk); #1;
    apply(mk(0, 0, 64'h0,    0, 1, 16'ha00, 0, 32'h0,   0, 64'h0,    0));
    apply(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));
    apply(mk(0, 1, 64'h1000, 0, 0, 16'h0,   0, 32'h0,   1, 64'h1000, 1));
    apply(mk(0, 0, 64'h0,    0, 1, 16'hb00, 1, 32'hb00, 0, 64'h0,    1));
    apply(mk(0, 0, 64'h0,    0, 0, 16'h0,   0, 32'h0,   0, 64'h0,    0));

    // 4-way, 8 sets, 4-instr lines: five lines into set 0.
    for (int i = 0; i < 5; i++) begin
      logic [63:0] a;
      logic [15:0] b;
      a = 64'(i) * 64'h80;
      b = 16'(16'h40 * (i + 1));
      apply4(mk(0, 1, a, 0, 0, 16'h0, 0, 32'h0, 1, a, 1));
      apply4(mk(0, 0, 64'h0, 0, 1, b, 1, {16'h0, b}, 0, 64'h0, 1));
      apply4(mk(0, 0, 64'h0, 0, 0, 16'h0, 0, 32'h0, 0, 64'h0, 0));
    end
    for (int i = 1; i < 5; i++) begin
      logic [15:0] b;
      b = 16'(16'h40 * (i + 1));
      apply4(mk(0, 1, 64'(i) * 64'h80 + 64'h4, 0, 0, 16'h0, 1, {16'h0, b} + 32'h1, 0, 64'h0, 0));
    end
    apply4(mk(0, 1, 64'h0008, 0, 0, 16'h0, 0, 32'h0,   1, 64'h0, 1));
    apply4(mk(0, 0, 64'h0,    0, 1, 16'hc0, 1, 32'hc2, 0, 64'h0, 1));
    apply4(mk(0, 0, 64'h0,    0, 0, 16'h0, 0, 32'h0,   0, 64'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errors);
    $finish;
  end

endmodule
